// File: rtl/halli_pkg.sv
// ---------------------------------------------------------------------------
// halli_pkg
// Shared definitions for the score_board block: presser (who) codes,
// result (LCD_sig) codes, the game FSM state type and a small helper that
// turns the two score comparisons into a result code.
// ---------------------------------------------------------------------------
package halli_pkg;

    // Presser codes carried on the who input
    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_A    = 2'b01;
    localparam logic [1:0] WHO_B    = 2'b10;
    localparam logic [1:0] WHO_BOTH = 2'b11;

    // Result codes shown on LCD_sig
    localparam logic [1:0] RES_PLAY = 2'b00;
    localparam logic [1:0] RES_A    = 2'b01;
    localparam logic [1:0] RES_B    = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    // Game FSM states
    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        SETTLE = 2'd1,
        OVER   = 2'd2
    } state_t;

    // Map the outcome of the score comparison onto a result code
    function automatic logic [1:0] result_code(input logic a_ahead, input logic b_ahead);
        logic [1:0] code;
        if (a_ahead) begin
            code = RES_A;
        end else if (b_ahead) begin
            code = RES_B;
        end else begin
            code = RES_DRAW;
        end
        return code;
    endfunction

endpackage

// File: rtl/score_board_score_counter.sv
// ---------------------------------------------------------------------------
// score_counter
// One player's score register. Counts up on inc (holding at the all-ones
// maximum), down on dec (holding at zero) and clears on clr.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low
//   clr        : synchronous clear, wins over inc/dec
//   inc        : add one point (saturating)
//   dec        : remove one point (floored at zero)
//   score      : registered score
//   score_next : value score takes at the next edge, so the parent can
//                judge the post-update score in the same cycle
// ---------------------------------------------------------------------------
module score_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] score,
    output logic [W-1:0] score_next
);

    localparam logic [W-1:0] MAX_SCORE = '1;

    // Next value: clear first, then saturating increment, then floored decrement
    always_comb begin
        score_next = score;
        if (clr) begin
            score_next = '0;
        end else if (inc) begin
            if (score != MAX_SCORE) begin
                score_next = score + 1'b1;
            end
        end else if (dec) begin
            if (score != '0) begin
                score_next = score - 1'b1;
            end
        end
    end

    // Score register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score <= '0;
        end else begin
            score <= score_next;
        end
    end

endmodule

// File: rtl/score_board.sv
// ---------------------------------------------------------------------------
// score_board
// Two-player bell game referee. Counts points for players A and B from
// bell-press results, counts accepted rounds, ends the game when a player
// reaches TARGET or the deck runs out, and then reports the winner.
//
// Parameters
//   SCORE_W : width of each score and of the round counter
//   TARGET  : score that ends the game
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active low
//   clr       : synchronous game restart, active high, highest priority
//   en        : one-cycle strobe, a round result is valid
//   who       : presser code (none / A / B / both)
//   right     : the press was correct
//   finish    : deck exhausted (level or pulse)
//   scoreA    : player A score
//   scoreB    : player B score
//   round_cnt : accepted strobes, saturating
//   LCD_sig   : result code (playing / A wins / B wins / draw)
//   game_over : high while in OVER
//
// Build option
//   SCORE_BOARD_PENALTY_EN : when defined, a wrong press (right=0) costs the
//                            pressing player(s) one point, floored at zero.
//                            Undefined, wrong presses leave the scores alone.
// ---------------------------------------------------------------------------
module score_board
    import halli_pkg::*;
#(
    parameter int SCORE_W = 8,
    parameter int TARGET  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [1:0]         who,
    input  logic               right,
    input  logic               finish,
    output logic [SCORE_W-1:0] scoreA,
    output logic [SCORE_W-1:0] scoreB,
    output logic [SCORE_W-1:0] round_cnt,
    output logic [1:0]         LCD_sig,
    output logic               game_over
);

    localparam logic [SCORE_W-1:0] MAX_ROUND = '1;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               load_result;
    logic               hit_a;
    logic               hit_b;
    logic               inc_a;
    logic               inc_b;
    logic               dec_a;
    logic               dec_b;
    logic               reached;
    logic [SCORE_W-1:0] a_next;
    logic [SCORE_W-1:0] b_next;

    // Decode which players took part in the press
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        case (who)
            WHO_NONE: begin
                hit_a = 1'b0;
                hit_b = 1'b0;
            end
            WHO_A: hit_a = 1'b1;
            WHO_B: hit_b = 1'b1;
            WHO_BOTH: begin
                hit_a = 1'b1;
                hit_b = 1'b1;
            end
            default: begin
                hit_a = 1'b0;
                hit_b = 1'b0;
            end
        endcase
    end

    // A correct press only scores for a single presser; both pressing is a tie
    assign inc_a = accept & right & hit_a & ~hit_b;
    assign inc_b = accept & right & hit_b & ~hit_a;

`ifdef SCORE_BOARD_PENALTY_EN
    assign dec_a = accept & ~right & hit_a;
    assign dec_b = accept & ~right & hit_b;
`else
    assign dec_a = 1'b0;
    assign dec_b = 1'b0;
`endif

    score_counter #(.W(SCORE_W)) u_score_a (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .inc        (inc_a),
        .dec        (dec_a),
        .score      (scoreA),
        .score_next (a_next)
    );

    score_counter #(.W(SCORE_W)) u_score_b (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .inc        (inc_b),
        .dec        (dec_b),
        .score      (scoreB),
        .score_next (b_next)
    );

    // Target check uses the post-update scores so the winning point ends the game
    assign reached = (32'(a_next) >= 32'(TARGET)) || (32'(b_next) >= 32'(TARGET));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PLAY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clr restarts from any state
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = PLAY;
        end else begin
            case (state)
                PLAY: begin
                    if (reached || finish) begin
                        state_next = SETTLE;
                    end
                end
                SETTLE:  state_next = OVER;
                OVER:    state_next = OVER;
                default: state_next = PLAY;
            endcase
        end
    end

    // FSM outputs: rounds are accepted only in PLAY, result latched leaving SETTLE
    always_comb begin
        accept      = 1'b0;
        load_result = 1'b0;
        game_over   = 1'b0;
        case (state)
            PLAY:    accept      = en & ~clr;
            SETTLE:  load_result = ~clr;
            OVER:    game_over   = 1'b1;
            default: accept      = 1'b0;
        endcase
    end

    // Round counter, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_cnt <= '0;
        end else if (clr) begin
            round_cnt <= '0;
        end else if (accept && (round_cnt != MAX_ROUND)) begin
            round_cnt <= round_cnt + 1'b1;
        end
    end

    // Result register, loaded once on entry to OVER from the frozen scores
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            LCD_sig <= RES_PLAY;
        end else if (clr) begin
            LCD_sig <= RES_PLAY;
        end else if (load_result) begin
            LCD_sig <= result_code(scoreA > scoreB, scoreB > scoreA);
        end
    end

endmodule

// File: tb/tb_score_board.sv
// ---------------------------------------------------------------------------
// tb_score_board
// Directed bench for score_board: a default instance (SCORE_W=8, TARGET=10)
// and a narrow instance (SCORE_W=4, TARGET=20) for saturation.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_score_board;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic [1:0] who = 2'b00;
    logic       right = 1'b0;
    logic       finish = 1'b0;
    logic [7:0] scoreA;
    logic [7:0] scoreB;
    logic [7:0] round_cnt;
    logic [1:0] LCD_sig;
    logic       game_over;

    logic       sClr = 1'b0;
    logic       sEn = 1'b0;
    logic [1:0] sWho = 2'b00;
    logic       sRight = 1'b0;
    logic       sFinish = 1'b0;
    logic [3:0] sScoreA;
    logic [3:0] sScoreB;
    logic [3:0] sRoundCnt;
    logic [1:0] sLcdSig;
    logic       sGameOver;

    int vectors = 0;
    int miscompares = 0;

    score_board #(.SCORE_W(8), .TARGET(10)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (en),
        .who       (who),
        .right     (right),
        .finish    (finish),
        .scoreA    (scoreA),
        .scoreB    (scoreB),
        .round_cnt (round_cnt),
        .LCD_sig   (LCD_sig),
        .game_over (game_over)
    );

    score_board #(.SCORE_W(4), .TARGET(20)) u_small (
        .clk       (clk),
        .rst       (rst),
        .clr       (sClr),
        .en        (sEn),
        .who       (sWho),
        .right     (sRight),
        .finish    (sFinish),
        .scoreA    (sScoreA),
        .scoreB    (sScoreB),
        .round_cnt (sRoundCnt),
        .LCD_sig   (sLcdSig),
        .game_over (sGameOver)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, step past the edge, then return to idle
    task automatic applyStimulus(input logic e, input logic [1:0] w, input logic r,
                                 input logic f, input logic c);
        en     = e;
        who    = w;
        right  = r;
        finish = f;
        clr    = c;
        @(posedge clk);
        #1;
        en     = 1'b0;
        who    = 2'b00;
        right  = 1'b0;
        finish = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held from time 0
        #3;
        checkOutput("rst_scoreA", 32'(scoreA), 0);
        checkOutput("rst_scoreB", 32'(scoreB), 0);
        checkOutput("rst_round", 32'(round_cnt), 0);
        checkOutput("rst_lcd", 32'(LCD_sig), 0);
        checkOutput("rst_over", 32'(game_over), 0);
        #5;
        rst = 1'b1;
        tick();
        checkOutput("idle_scoreA", 32'(scoreA), 0);

        // Three correct A rounds, one-cycle latency
        en = 1'b1; who = 2'b01; right = 1'b1;
        #1;
        checkOutput("lat_before_edge", 32'(scoreA), 0);
        en = 1'b0; who = 2'b00; right = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
            checkOutput("a3_scoreA", 32'(scoreA), 32'(i));
            checkOutput("a3_round", 32'(round_cnt), 32'(i));
        end
        checkOutput("a3_scoreB", 32'(scoreB), 0);

        // Drive A to 9, then the winning point
        for (int i = 4; i <= 9; i++) begin
            applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("a9_scoreA", 32'(scoreA), 9);
        checkOutput("a9_over", 32'(game_over), 0);
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        checkOutput("tgt_scoreA", 32'(scoreA), 10);
        checkOutput("tgt_round", 32'(round_cnt), 10);
        checkOutput("settle_over", 32'(game_over), 0);
        checkOutput("settle_lcd", 32'(LCD_sig), 0);
        tick();
        checkOutput("tgt_over", 32'(game_over), 1);
        checkOutput("tgt_lcd", 32'(LCD_sig), 1);
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        checkOutput("over_ign_scoreA", 32'(scoreA), 10);
        checkOutput("over_ign_round", 32'(round_cnt), 10);

        // clr in OVER together with en: en ignored
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_scoreA", 32'(scoreA), 0);
        checkOutput("clr_round", 32'(round_cnt), 0);
        checkOutput("clr_lcd", 32'(LCD_sig), 0);
        checkOutput("clr_over", 32'(game_over), 0);

        // 4:4 then deck end -> draw
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        checkOutput("d44_round", 32'(round_cnt), 8);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("d44_settle_over", 32'(game_over), 0);
        tick();
        checkOutput("d44_over", 32'(game_over), 1);
        checkOutput("d44_lcd", 32'(LCD_sig), 3);

        // en and finish together: point first, then B wins 5:0
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
        checkOutput("ef_scoreB", 32'(scoreB), 5);
        checkOutput("ef_settle_over", 32'(game_over), 0);
        tick();
        checkOutput("ef_lcd", 32'(LCD_sig), 2);
        checkOutput("ef_over", 32'(game_over), 1);

        // finish held across clr: one PLAY cycle, then the game ends again
        clr = 1'b1; finish = 1'b1;
        tick();
        checkOutput("hold_clr_over", 32'(game_over), 0);
        checkOutput("hold_clr_scoreB", 32'(scoreB), 0);
        clr = 1'b0;
        tick();
        checkOutput("hold_settle_over", 32'(game_over), 0);
        tick();
        checkOutput("hold_over", 32'(game_over), 1);
        checkOutput("hold_lcd", 32'(LCD_sig), 3);
        finish = 1'b0;

        // Wrong press by both players
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        checkOutput("pen_scoreA", 32'(scoreA), 0);
`ifdef SCORE_BOARD_PENALTY_EN
        checkOutput("pen_scoreB", 32'(scoreB), 1);
`else
        checkOutput("pen_scoreB", 32'(scoreB), 2);
`endif
        checkOutput("pen_round", 32'(round_cnt), 3);

        // Finish the game, then reset between edges
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("pre_rst_lcd", 32'(LCD_sig), 2);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_scoreB", 32'(scoreB), 0);
        checkOutput("mid_rst_round", 32'(round_cnt), 0);
        checkOutput("mid_rst_lcd", 32'(LCD_sig), 0);
        checkOutput("mid_rst_over", 32'(game_over), 0);
        en = 1'b1; who = 2'b01; right = 1'b1;
        #2;
        rst = 1'b1;
        tick();
        en = 1'b0; who = 2'b00; right = 1'b0;
        checkOutput("post_rst_scoreA", 32'(scoreA), 1);
        checkOutput("post_rst_round", 32'(round_cnt), 1);

        // Narrow instance: 16 correct A rounds saturate at 15
        sEn = 1'b1; sWho = 2'b01; sRight = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        sEn = 1'b0; sWho = 2'b00; sRight = 1'b0;
        tick();
        checkOutput("sat_scoreA", 32'(sScoreA), 15);
        checkOutput("sat_round", 32'(sRoundCnt), 15);
        checkOutput("sat_scoreB", 32'(sScoreB), 0);
        checkOutput("sat_over", 32'(sGameOver), 0);
        checkOutput("sat_lcd", 32'(sLcdSig), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_board.md
SCORE_BOARD -- requirements
Module: score_board

Interface
REQ-001 SHALL have parameter SCORE_W, default 8, score and round-counter width in bits.
REQ-002 SHALL have parameter TARGET, default 10, score that ends the game when reached.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clr  input  1  synchronous game restart, active-high.
REQ-006 SHALL have port en  input  1  one-cycle strobe; a bell-press round result is valid.
REQ-007 SHALL have port who  input  2  presser code: 00 none, 01 player A, 10 player B, 11 both.
REQ-008 SHALL have port right  input  1  the bell press was correct (a fruit total equals five).
REQ-009 SHALL have port finish  input  1  the card deck is exhausted, level or pulse.
REQ-010 SHALL have port scoreA  output  SCORE_W  player A score.
REQ-011 SHALL have port scoreB  output  SCORE_W  player B score.
REQ-012 SHALL have port round_cnt  output  SCORE_W  number of accepted en strobes.
REQ-013 SHALL have port LCD_sig  output  2  result code: 00 playing, 01 A wins, 10 B wins, 11 draw.
REQ-014 SHALL have port game_over  output  1  high while the state is OVER.

Function
REQ-015 SHALL implement the FSM states PLAY, SETTLE and OVER.
REQ-016 SHALL, in PLAY with en=1, right=1 and who=01, increment scoreA; with who=10, increment scoreB; with who=11 or who=00, leave both scores unchanged.
REQ-017 SHALL saturate each score at 2^SCORE_W-1; an increment at the maximum holds the value.
REQ-018 SHALL increment round_cnt on every en strobe accepted in PLAY, whatever the values of who and right, saturating at 2^SCORE_W-1.
REQ-019 SHALL make score and round_cnt updates visible in the cycle after en is sampled (1-cycle latency).
REQ-020 SHALL move PLAY->SETTLE when, at a clock edge in PLAY, the post-update scoreA>=TARGET, the post-update scoreB>=TARGET, or finish=1.
REQ-021 SHALL, when en and finish are both high in the same cycle, apply the en update first and then take the transition to SETTLE.
REQ-022 SHALL remain in SETTLE for exactly one cycle, freezing the scores, and then move to OVER.
REQ-023 SHALL register LCD_sig on entry to OVER: 01 if scoreA>scoreB, 10 if scoreB>scoreA, 11 if they are equal.
REQ-024 SHALL hold LCD_sig at 00 in PLAY and SETTLE.
REQ-025 SHALL ignore en and finish in SETTLE and OVER.
REQ-026 SHALL remain in OVER until clr or reset.
REQ-027 SHALL, on clr=1 in any state, zero scoreA, scoreB, round_cnt and LCD_sig and enter PLAY on the next edge; clr has priority over en and finish in the same cycle.
REQ-028 SHALL NOT re-trigger SETTLE from a finish that is still high after clr; the deck-end condition is re-evaluated only in PLAY, so a held finish ends the new game after one PLAY cycle.

Reset
REQ-029 SHALL, while rst=0, force the state to PLAY and scoreA, scoreB, round_cnt, LCD_sig and game_over to 0, independently of clk.
REQ-030 SHALL make the first state update on the first rising clk edge after rst is released, with no extra idle cycle.

Configuration
REQ-031 SHALL support the macro SCORE_BOARD_PENALTY_EN.
REQ-032 SHALL, with SCORE_BOARD_PENALTY_EN defined, apply penalties in PLAY when en=1 and right=0: who=01 decrements scoreA, who=10 decrements scoreB, who=11 decrements both; each score floors at 0.
REQ-033 SHALL, without SCORE_BOARD_PENALTY_EN, treat right=0 rounds as score no-ops that still increment round_cnt.

Structure
REQ-034 SHALL place the following in shared package halli_pkg: the who codes (WHO_NONE, WHO_A, WHO_B, WHO_BOTH), the LCD_sig codes (RES_PLAY, RES_A, RES_B, RES_DRAW) and the FSM state enum.
REQ-035 SHALL implement each score in one sub-module, score_counter, instantiated twice, with inputs inc, dec and clr, saturating at the maximum and flooring at 0.
REQ-036 SHALL keep the FSM and winner comparison in score_board itself.

Verification
REQ-037 SHALL cover: reset, then 3 strobes en=1/right=1/who=01 -> scoreA=3, scoreB=0, round_cnt=3, each update one cycle after its en.
REQ-038 SHALL cover: TARGET=10, scoreA=9, en with who=01/right=1 -> scoreA=10, SETTLE one cycle, then OVER with LCD_sig=01 and game_over=1; later en ignored.
REQ-039 SHALL cover: scoreA=4, scoreB=4, finish pulse -> OVER with LCD_sig=11; en and finish pulses in the same cycle with who=10 and scoreB=4 -> scoreB=5 and LCD_sig=10.
REQ-040 SHALL cover: PENALTY_EN defined, scoreA=0 and scoreB=2, en with right=0/who=11 -> scoreA=0, scoreB=1; without the macro -> scores unchanged, round_cnt+1.
REQ-041 SHALL cover: SCORE_W=4, TARGET=20, 16 correct A rounds -> scoreA saturates at 15 and round_cnt saturates at 15.
REQ-042 SHALL cover: rst asserted mid-game between clock edges -> all outputs 0 immediately; clr in OVER together with en -> PLAY with zeroed scores and the en ignored.
